input_port_ctrl: RTL and testbench

//   Per-port packet controller sitting directly downstream of fifo_buffer in each router input port.

---
 rtl/input_port_ctrl.sv | 82 ++++++++
 tb/tb_input_port_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl.sv
// Router input-port controller: requests a route for the packet at the FIFO head,
// then streams header, size and payload flits to the crossbar under credit flow control.
module input_port_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_head,
    input  logic [$clog2(DEPTH):0]   i_counter,
    output logic                     o_pull,
    output logic                     o_req_route,
    output logic [WIDTH-1:0]         o_header,
    input  logic                     i_ack_route,
    output logic                     o_sender,
    output logic                     o_data_av,
    output logic [WIDTH-1:0]         o_data,
    input  logic                     i_credit,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD,
        S_END
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] flits_left, flits_left_nx;
    logic             avail, sending, xfer;

    assign avail   = (i_counter != '0);
    assign sending = (state == S_HEADER) || (state == S_SIZE) || (state == S_PAYLOAD);
    assign xfer    = o_data_av & i_credit;

    assign o_data_av   = sending & avail;
    assign o_sender    = sending;
    assign o_pull      = xfer;
    assign o_req_route = (state == S_REQ);
    assign o_done      = (state == S_END);
    assign o_data      = i_head;
    assign o_header    = i_head;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            flits_left <= '0;
        end else begin
            state      <= state_nx;
            flits_left <= flits_left_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        flits_left_nx = flits_left;
        case (state)
            S_IDLE:   if (avail) state_nx = S_REQ;
            // Header stays in the FIFO until the route is granted.
            S_REQ:    if (i_ack_route) state_nx = S_HEADER;
            S_HEADER: if (xfer) state_nx = S_SIZE;
            S_SIZE: begin
                if (xfer) begin
                    flits_left_nx = i_head;
                    state_nx      = (i_head == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    flits_left_nx = flits_left - 1'b1;
                    if (flits_left == WIDTH'(1)) state_nx = S_END;
                end
            end
            S_END:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: a queue models fifo_buffer; directed scenarios plus a
// randomized packet stream checked against a packet-level flit/done expectation.
module tb_input_port_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_head;
    logic [3:0]  i_counter;
    logic        o_pull;
    logic        o_req_route;
    logic [15:0] o_header;
    logic        i_ack_route;
    logic        o_sender;
    logic        o_data_av;
    logic [15:0] o_data;
    logic        i_credit;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] fifo[$];
    logic pull_s;

    input_port_ctrl #(.WIDTH(16), .DEPTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_head(i_head), .i_counter(i_counter),
        .o_pull(o_pull), .o_req_route(o_req_route), .o_header(o_header),
        .i_ack_route(i_ack_route), .o_sender(o_sender), .o_data_av(o_data_av),
        .o_data(o_data), .i_credit(i_credit), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic upd();
        i_counter = 4'(fifo.size());
        if (fifo.size() != 0) i_head = fifo[0];
        else i_head = '0;
    endtask

    task automatic push(input logic [15:0] v);
        fifo.push_back(v);
        upd();
    endtask

    // One clock: FIFO pops at the edge if the DUT pulled during the cycle.
    task automatic tick();
        #1;
        pull_s = o_pull;
        @(posedge i_clk);
        #1;
        if (pull_s && fifo.size() != 0) void'(fifo.pop_front());
        upd();
    endtask

    task automatic do_reset();
        i_rst = 1'b0; i_credit = 1'b0; i_ack_route = 1'b0;
        fifo.delete(); upd();
        tick(); tick();
        i_rst = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_req_route) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_credit = 1'b1; i_ack_route = 1'b0;
        fifo.delete(); upd();
        tick(); tick();
        @(negedge i_clk);
        checks++; if ({o_pull, o_req_route, o_sender, o_data_av, o_done} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {o_pull, o_req_route, o_sender, o_data_av, o_done});
        end
        checks++; if (dut.flits_left !== 16'd0) begin
            errors++; $display("FAIL reset_flits_left: got %0d expected 0", dut.flits_left);
        end
        // A non-empty FIFO must not provoke a request while reset is held.
        push(16'h0001);
        tick();
        @(negedge i_clk);
        checks++; if (o_req_route !== 1'b0) begin
            errors++; $display("FAIL reset_hold_req: got %b expected 0", o_req_route);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        push(16'h0099); push(16'd3); push(16'hA001); push(16'hA002); push(16'hA003);
        i_credit = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_req_timeout: got no request expected one"); end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        @(negedge i_clk);
        checks++; if (o_data_av !== 1'b1 || o_data !== 16'hA002) begin
            errors++; $display("FAIL rstmid_in_payload: got av=%b data=%h expected av=1 data=a002", o_data_av, o_data);
        end
        i_rst = 1'b0;
        tick();
        @(negedge i_clk);
        checks++; if ({o_sender, o_data_av, o_pull, o_req_route, o_done} !== 5'b0) begin
            errors++; $display("FAIL rstmid_idle: got %b expected 00000", {o_sender, o_data_av, o_pull, o_req_route, o_done});
        end
        fifo.delete(); upd();
        tick(); i_rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] pkt[4];
        bit ok;
        pkt[0] = 16'h0011; pkt[1] = 16'h0002; pkt[2] = 16'hAAAA; pkt[3] = 16'hBBBB;
        do_reset();
        for (int k = 0; k < 4; k++) push(pkt[k]);
        i_credit = 1'b1;
        @(negedge i_clk);
        checks++; if (o_req_route !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b expected 0", o_req_route); end
        tick();
        @(negedge i_clk);
        checks++; if (o_req_route !== 1'b1 || o_header !== 16'h0011) begin
            errors++; $display("FAIL basic_req: got req=%b hdr=%h expected req=1 hdr=0011", o_req_route, o_header);
        end
        for (int w = 0; w < 2; w++) begin
            tick();
            @(negedge i_clk);
            checks++; if (o_req_route !== 1'b1 || o_pull !== 1'b0) begin
                errors++; $display("FAIL basic_req_hold: got req=%b pull=%b expected req=1 pull=0", o_req_route, o_pull);
            end
        end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++; if (o_data_av !== 1'b1 || o_pull !== 1'b1 || o_data !== pkt[k]) begin
                errors++; $display("FAIL basic_flit%0d: got av=%b pull=%b data=%h expected 1 1 %h", k, o_data_av, o_pull, o_data, pkt[k]);
            end
            tick();
        end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1 || o_sender !== 1'b0) begin
            errors++; $display("FAIL basic_done: got done=%b sender=%b expected 1 0", o_done, o_sender);
        end
        tick();
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0 || o_sender !== 1'b0) begin
            errors++; $display("FAIL basic_after_done: got done=%b sender=%b expected 0 0", o_done, o_sender);
        end
    endtask

    task automatic test_zero_size();
        bit ok;
        do_reset();
        push(16'h0022); push(16'h0000); push(16'h0033);
        i_credit = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_req_timeout: got no request expected one"); end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checks++; if (o_pull !== 1'b1) begin errors++; $display("FAIL zero_xfer%0d: got pull=%b expected 1", k, o_pull); end
            tick();
        end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1 || o_pull !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b pull=%b expected 1 0", o_done, o_pull);
        end
        tick();
        checks++; if (fifo.size() != 1) begin
            errors++; $display("FAIL zero_no_payload_pull: got fifo=%0d expected 1", fifo.size());
        end
    endtask

    task automatic test_credit();
        logic [15:0] pkt[5];
        int xfers, cyc;
        bit ok;
        pkt[0] = 16'h0044; pkt[1] = 16'd3; pkt[2] = 16'hC001; pkt[3] = 16'hC002; pkt[4] = 16'hC003;
        do_reset();
        for (int k = 0; k < 5; k++) push(pkt[k]);
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL credit_req_timeout: got no request expected one"); end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        xfers = 0; cyc = 0;
        while (xfers < 5 && cyc < 30) begin
            i_credit = (cyc % 2 == 0);
            @(negedge i_clk);
            checks++; if (o_pull !== i_credit || o_data_av !== 1'b1) begin
                errors++; $display("FAIL credit_pull_c%0d: got pull=%b av=%b expected %b 1", cyc, o_pull, o_data_av, i_credit);
            end
            if (o_pull) begin
                checks++; if (o_data !== pkt[xfers]) begin
                    errors++; $display("FAIL credit_data%0d: got %h expected %h", xfers, o_data, pkt[xfers]);
                end
                xfers++;
            end
            tick(); cyc++;
        end
        checks++; if (xfers != 5 || cyc != 9) begin
            errors++; $display("FAIL credit_count: got xfers=%0d cycles=%0d expected 5 9", xfers, cyc);
        end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL credit_done: got %b expected 1", o_done); end
        i_credit = 1'b0;
    endtask

    task automatic test_stall();
        logic [15:0] pkt[6];
        bit ok;
        pkt[0] = 16'h0055; pkt[1] = 16'd4; pkt[2] = 16'hD001; pkt[3] = 16'hD002; pkt[4] = 16'hD003; pkt[5] = 16'hD004;
        do_reset();
        for (int k = 0; k < 4; k++) push(pkt[k]);
        i_credit = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout: got no request expected one"); end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++; if (o_pull !== 1'b1 || o_data !== pkt[k]) begin
                errors++; $display("FAIL stall_pre%0d: got pull=%b data=%h expected 1 %h", k, o_pull, o_data, pkt[k]);
            end
            tick();
        end
        for (int g = 0; g < 5; g++) begin
            @(negedge i_clk);
            checks++; if (o_data_av !== 1'b0 || o_pull !== 1'b0 || o_sender !== 1'b1 || dut.flits_left !== 16'd2) begin
                errors++; $display("FAIL stall_gap%0d: got av=%b pull=%b snd=%b left=%0d expected 0 0 1 2", g, o_data_av, o_pull, o_sender, dut.flits_left);
            end
            tick();
        end
        push(pkt[4]); push(pkt[5]);
        for (int k = 4; k < 6; k++) begin
            @(negedge i_clk);
            checks++; if (o_pull !== 1'b1 || o_data !== pkt[k]) begin
                errors++; $display("FAIL stall_post%0d: got pull=%b data=%h expected 1 %h", k, o_pull, o_data, pkt[k]);
            end
            tick();
        end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", o_done); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        push(16'h0066); push(16'h0000); push(16'h0077); push(16'h0001); push(16'h0088);
        i_credit = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_req_timeout: got no request expected one"); end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        tick(); tick();
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", o_done); end
        tick();
        @(negedge i_clk);
        checks++; if (o_req_route !== 1'b0) begin errors++; $display("FAIL b2b_req_early: got %b expected 0", o_req_route); end
        tick();
        @(negedge i_clk);
        checks++; if (o_req_route !== 1'b1 || o_header !== 16'h0077) begin
            errors++; $display("FAIL b2b_req2: got req=%b hdr=%h expected 1 0077", o_req_route, o_header);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge i_clk);
            checks++; if (o_pull !== 1'b0 || fifo.size() != 3) begin
                errors++; $display("FAIL b2b_hold%0d: got pull=%b fifo=%0d expected 0 3", w, o_pull, fifo.size());
            end
            tick();
        end
        i_ack_route = 1'b1; tick(); i_ack_route = 1'b0;
        tick(); tick(); tick();
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1 || fifo.size() != 0) begin
            errors++; $display("FAIL b2b_done2: got done=%b fifo=%0d expected 1 0", o_done, fifo.size());
        end
    endtask

    task automatic test_random();
        logic [15:0] src[$];
        logic [15:0] exp[$];
        int lens[$];
        int npk, n, done_cnt, cnt, cyc;
        bit done_due, done_nxt;
        npk = 25; done_cnt = 0; cnt = 0; cyc = 0; done_due = 1'b0;
        do_reset();
        for (int p = 0; p < npk; p++) begin
            n = $urandom_range(0, 5);
            src.push_back(16'($urandom));
            src.push_back(16'(n));
            for (int k = 0; k < n; k++) src.push_back(16'($urandom));
            lens.push_back(n + 2);
        end
        exp = src;
        while (done_cnt < npk && cyc < 5000) begin
            i_credit    = ($urandom % 4) != 0;
            i_ack_route = ($urandom % 3) == 0;
            @(negedge i_clk);
            checks++; if (o_pull !== (o_data_av & i_credit)) begin
                errors++; $display("FAIL rnd_pull c%0d: got %b expected %b", cyc, o_pull, o_data_av & i_credit);
            end
            if (o_data_av) begin
                checks++; if (i_counter == 0 || o_sender !== 1'b1) begin
                    errors++; $display("FAIL rnd_av c%0d: got cnt=%0d snd=%b expected cnt>0 snd=1", cyc, i_counter, o_sender);
                end
            end
            if (o_req_route) begin
                checks++; if (o_sender !== 1'b0 || exp.size() == 0 || o_header !== exp[0]) begin
                    errors++; $display("FAIL rnd_req c%0d: got snd=%b hdr=%h expected 0 and next header", cyc, o_sender, o_header);
                end
            end
            done_nxt = 1'b0;
            if (o_pull) begin
                checks++; if (exp.size() == 0 || o_data !== exp[0]) begin
                    errors++; $display("FAIL rnd_data c%0d: got %h expected %h", cyc, o_data, exp.size() ? exp[0] : 16'h0);
                end
                if (exp.size() != 0) void'(exp.pop_front());
                cnt++;
                if (lens.size() != 0 && cnt == lens[0]) begin
                    done_nxt = 1'b1; cnt = 0; void'(lens.pop_front());
                end
            end
            checks++; if (o_done !== done_due) begin
                errors++; $display("FAIL rnd_done c%0d: got %b expected %b", cyc, o_done, done_due);
            end
            if (o_done) done_cnt++;
            done_due = done_nxt;
            tick();
            if (src.size() != 0 && fifo.size() < 8 && ($urandom % 3) != 0) push(src.pop_front());
            cyc++;
        end
        checks++; if (done_cnt != npk || exp.size() != 0) begin
            errors++; $display("FAIL rnd_complete: got %0d packets %0d flits left expected %0d packets 0 left", done_cnt, exp.size(), npk);
        end
        i_credit = 1'b0; i_ack_route = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0; i_credit = 1'b0; i_ack_route = 1'b0;
        upd();
        test_reset();
        test_reset_mid();
        test_basic();
        test_zero_size();
        test_credit();
        test_stall();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
